// File: rtl/mux_unstriping_pkg.sv
// mux_unstriping_pkg: shared constants and helpers for the N-lane unstriper.
package mux_unstriping_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 4;
    localparam int DEF_DEPTH = 4;
    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mux_unstriping_n_lane_fifo.sv
// lane_fifo: single-clock FIFO with occupancy count; pointers wrap mod DEPTH (power of 2).
module lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/mux_unstriping_n.sv
// mux_unstriping_n: re-serialises LANES striped input lanes in strict lane order.
// Optional MUX_UNSTRIPING_N_STATS_EN adds stall_cnt and skew_max statistics outputs.
module mux_unstriping_n
    import mux_unstriping_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    localparam int LW = lane_w(LANES),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                     clk_2f,
    input  logic                     reset_L,
    input  logic [LANES*WIDTH-1:0]   data_in,
    input  logic [LANES-1:0]         valid_in,
    output logic [LANES-1:0]         ready_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [LW-1:0]            lane_out,
    output logic                     active
`ifdef MUX_UNSTRIPING_N_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [CW-1:0]            skew_max
`endif
);
    logic [LANES-1:0]           full, empty, pop;
    logic [WIDTH-1:0]           head [LANES];
    logic [LANES-1:0][CW-1:0]   cnt;
    logic [LW-1:0]              rd_lane_q, rd_lane_d, lane_q, lane_d;
    logic [WIDTH-1:0]           data_q, data_d;
    logic                       valid_q, valid_d, active_q, active_d, rdy_en_q;
    logic                       free, load;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk_2f),
            .rst_n   (reset_L),
            .push_i  (valid_in[i] && ready_out[i]),
            .pop_i   (pop[i]),
            .din_i   (data_in[i*WIDTH +: WIDTH]),
            .dout_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .count_o (cnt[i])
        );
    end

    // ready is held low until the first edge after reset release
    assign ready_out = {LANES{rdy_en_q}} & ~full;
    assign free      = !valid_q || ready_in;
    assign load      = free && !empty[rd_lane_q];
    assign pop       = {{(LANES-1){1'b0}}, load} << rd_lane_q;

    always_comb begin
        rd_lane_d = load ? ((rd_lane_q == LW'(LANES - 1)) ? '0 : rd_lane_q + 1'b1) : rd_lane_q;
        lane_d    = load ? rd_lane_q : lane_q;
        data_d    = load ? head[rd_lane_q] : data_q;
        valid_d   = load || (valid_q && !ready_in);
        active_d  = active_q || load;
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            rd_lane_q <= '0;
            lane_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            rd_lane_q <= rd_lane_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            rdy_en_q  <= 1'b1;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_out  = lane_q;
    assign active    = active_q;

`ifdef MUX_UNSTRIPING_N_STATS_EN
    logic [15:0]   stall_q, stall_d;
    logic [CW-1:0] skew_q, skew_d, occ_max, occ_min;

    always_comb begin
        occ_max = cnt[0];
        occ_min = cnt[0];
        for (int k = 1; k < LANES; k++) begin
            occ_max = (cnt[k] > occ_max) ? cnt[k] : occ_max;
            occ_min = (cnt[k] < occ_min) ? cnt[k] : occ_min;
        end
        stall_d = (free && empty[rd_lane_q] && !(&empty) && stall_q != SAT_MAX) ? stall_q + 1'b1 : stall_q;
        skew_d  = ((occ_max - occ_min) > skew_q) ? occ_max - occ_min : skew_q;
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            stall_q <= '0;
            skew_q  <= '0;
        end else begin
            stall_q <= stall_d;
            skew_q  <= skew_d;
        end
    end

    assign stall_cnt = stall_q;
    assign skew_max  = skew_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif
endmodule
